// File: rtl/icache_waysel_stage_if.sv
// Bus bundle for icache_waysel_stage: S0 tag-array read, S1 ITLB/pipeline controls and the S1
// way-select / parity / retry results. Master drives the inputs; slave is the stage itself.
interface icache_waysel_stage_if #(
  parameter int unsigned TAG_W = 29,
  parameter int unsigned CNT_W = 8
);
  // S0 tag-array read
  logic                 rd_vld_s0;
  logic [4*TAG_W-1:0]   tags_s0;
  logic [3:0]           tagv_s0;
  logic [3:0]           tagpar_s0;
  // S1 controls and ITLB lookup
  logic                 stall_s1;
  logic                 flush_s1;
  logic [TAG_W-1:0]     ptag_s1;
  logic                 cam_vld_s1;
  logic                 tlb_cam_miss_s1;
  // S1 results
  logic [3:0]           waysel_buf_s1;
  logic [3:0]           alltag_err_s1;
  logic                 hit_s1;
  logic                 miss_s1;
  logic                 multihit_s1;
  logic                 retry_req;
  logic                 fatal_err;
  logic [CNT_W-1:0]     tag_err_cnt;

  modport master (
    output rd_vld_s0, tags_s0, tagv_s0, tagpar_s0,
    output stall_s1, flush_s1, ptag_s1, cam_vld_s1, tlb_cam_miss_s1,
    input  waysel_buf_s1, alltag_err_s1, hit_s1, miss_s1, multihit_s1,
    input  retry_req, fatal_err, tag_err_cnt
  );

  modport slave (
    input  rd_vld_s0, tags_s0, tagv_s0, tagpar_s0,
    input  stall_s1, flush_s1, ptag_s1, cam_vld_s1, tlb_cam_miss_s1,
    output waysel_buf_s1, alltag_err_s1, hit_s1, miss_s1, multihit_s1,
    output retry_req, fatal_err, tag_err_cnt
  );
endinterface

// File: rtl/icache_waysel_stage.sv
// S0->S1 stage of the icache tag path: registers the 4-way tag read, compares it against the
// ITLB physical tag and produces way-select / hit / miss / multihit. With
// ICACHE_WAYSEL_PARITY_EN defined it also checks tag parity, counts parity events and
// sequences fetch replays (retry_req pulses, fatal_err once replays are exhausted).
module icache_waysel_stage #(
  parameter int unsigned TAG_W     = 29,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned CNT_W     = 8
) (
  input logic                  clk,
  input logic                  rst_l,
  icache_waysel_stage_if.slave bus
);

  logic               vld_q, vld_d;
  logic [4*TAG_W-1:0] tags_q, tags_d;
  logic [3:0]         tagv_q, tagv_d;
  logic [3:0]         match;
  logic [3:0]         perr;
  logic               err_any;
  logic               ev;

  // S1 load: flush beats stall, stall holds, otherwise take the S0 read
  always_comb begin
    vld_d  = vld_q;
    tags_d = tags_q;
    tagv_d = tagv_q;
    if (bus.flush_s1) begin
      vld_d = 1'b0;
    end else if (!bus.stall_s1) begin
      vld_d  = bus.rd_vld_s0;
      tags_d = bus.tags_s0;
      tagv_d = bus.tagv_s0;
    end
  end

  // S1 pipeline registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_q  <= 1'b0;
      tags_q <= '0;
      tagv_q <= '0;
    end else begin
      vld_q  <= vld_d;
      tags_q <= tags_d;
      tagv_q <= tagv_d;
    end
  end

`ifdef ICACHE_WAYSEL_PARITY_EN
  logic [3:0] par_q, par_d;

  // Parity bits follow the same load/hold policy as the tags
  always_comb begin
    par_d = par_q;
    if (!bus.flush_s1 && !bus.stall_s1) par_d = bus.tagpar_s0;
  end

  // S1 parity register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) par_q <= '0;
    else        par_q <= par_d;
  end
`endif

  // Per-way tag compare and even-parity check
  always_comb begin
    match = '0;
    perr  = '0;
    for (int i = 0; i < 4; i++) begin
      match[i] = vld_q & tagv_q[i] & (tags_q[i*TAG_W +: TAG_W] == bus.ptag_s1);
`ifdef ICACHE_WAYSEL_PARITY_EN
      perr[i]  = vld_q & tagv_q[i] & (^{tags_q[i*TAG_W +: TAG_W], par_q[i]});
`endif
    end
  end

  assign err_any = |perr;
  // A lookup only counts when the ITLB hit and the stage is not stalled
  assign ev      = vld_q & bus.cam_vld_s1 & ~bus.tlb_cam_miss_s1 & ~bus.stall_s1;

  assign bus.waysel_buf_s1 = match;
  assign bus.hit_s1        = ev & (|match) & ~err_any;
  assign bus.miss_s1       = ev & ~(|match) & ~err_any;
  // More than one bit set <=> clearing the lowest set bit leaves something behind
  assign bus.multihit_s1   = ev & ((match & (match - 4'd1)) != 4'd0) & ~err_any;

`ifdef ICACHE_WAYSEL_PARITY_EN
  localparam int unsigned RcW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RcW-1:0] MaxRc = RcW'(MAX_RETRY);

  typedef enum logic [1:0] {StIdle, StRetry, StWait, StFatal} state_e;

  state_e           state_q;
  logic [RcW-1:0]   rc_q;
  logic             retry_q;
  logic             fatal_q;
  logic [CNT_W-1:0] cnt_q;

  // Replay sequencer; retry_req is high only while in StRetry
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= StIdle;
      rc_q    <= '0;
      retry_q <= 1'b0;
      fatal_q <= 1'b0;
    end else begin
      retry_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ev && err_any) begin
            state_q <= StRetry;
            rc_q    <= RcW'(1);
            retry_q <= 1'b1;
          end
        end
        StRetry: begin
          // The pulse already went out; a flush only changes where we land
          if (bus.flush_s1) begin
            state_q <= StIdle;
            rc_q    <= '0;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (ev && err_any) begin
            if (rc_q < MaxRc) begin
              state_q <= StRetry;
              rc_q    <= rc_q + RcW'(1);
              retry_q <= 1'b1;
            end else begin
              state_q <= StFatal;
              fatal_q <= 1'b1;
            end
          end else if (ev || bus.flush_s1) begin
            state_q <= StIdle;
            rc_q    <= '0;
          end
        end
        StFatal: fatal_q <= 1'b1;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Saturating parity-event counter
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
    end else if (ev && err_any && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.alltag_err_s1 = perr;
  assign bus.retry_req     = retry_q;
  assign bus.fatal_err     = fatal_q;
  assign bus.tag_err_cnt   = cnt_q;
`else
  // Parity inputs and replay configuration are intentionally unused in this build
  logic unused_cfg;
  assign unused_cfg = ^{bus.tagpar_s0, perr, 32'(MAX_RETRY), 32'(CNT_W)};

  assign bus.alltag_err_s1 = 4'b0;
  assign bus.retry_req     = 1'b0;
  assign bus.fatal_err     = 1'b0;
  assign bus.tag_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_icache_waysel_stage.sv
// Bench for icache_waysel_stage: directed vectors with literal expectations plus a per-cycle
// compare against a behavioural model of the stage (built with or without
// ICACHE_WAYSEL_PARITY_EN, matching the DUT).
module tb_icache_waysel_stage;
  localparam int unsigned TAG_W     = 29;
  localparam int unsigned MAX_RETRY = 2;
  localparam int unsigned CNT_W     = 8;
  localparam logic [TAG_W-1:0] PT   = 29'h0ABC_DEF1;
`ifdef ICACHE_WAYSEL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  icache_waysel_stage_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  icache_waysel_stage #(
    .TAG_W    (TAG_W),
    .MAX_RETRY(MAX_RETRY),
    .CNT_W    (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic             m_vld;
  logic [TAG_W-1:0] m_tag [4];
  logic [3:0]       m_tagv, m_par;
  int               m_cnt, m_rc;
  bit               m_rr, m_wait, m_fatal;
  logic             n_vld;
  logic [TAG_W-1:0] n_tag [4];
  logic [3:0]       n_tagv, n_par;
  int               n_cnt, n_rc;
  bit               n_rr, n_wait, n_fatal;

  // Check outputs against the model mid-cycle, then work out the model's next state
  always @(negedge clk) begin
    logic [3:0] e_match, e_perr;
    bit ev, err;
    if (!rst_l) begin
      m_vld = 0; m_tagv = 0; m_par = 0; m_cnt = 0; m_rc = 0;
      m_rr = 0; m_wait = 0; m_fatal = 0;
      for (int i = 0; i < 4; i++) m_tag[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      e_match[i] = m_vld && m_tagv[i] && (m_tag[i] == bus.ptag_s1);
      e_perr[i]  = PAR_EN && m_vld && m_tagv[i] && ((^m_tag[i]) != m_par[i]);
    end
    ev  = m_vld && bus.cam_vld_s1 && !bus.tlb_cam_miss_s1 && !bus.stall_s1;
    err = (e_perr != 4'd0);
    chk("m_waysel",  32'(bus.waysel_buf_s1), 32'(e_match));
    chk("m_alltag",  32'(bus.alltag_err_s1), 32'(e_perr));
    chk("m_hit",     32'(bus.hit_s1),   32'(ev && e_match != 0 && !err));
    chk("m_miss",    32'(bus.miss_s1),  32'(ev && e_match == 0 && !err));
    chk("m_multi",   32'(bus.multihit_s1), 32'(ev && $countones(e_match) > 1 && !err));
    chk("m_retry",   32'(bus.retry_req), 32'(m_rr));
    chk("m_fatal",   32'(bus.fatal_err), 32'(m_fatal));
    chk("m_cnt",     32'(bus.tag_err_cnt), 32'(m_cnt));
    // next state
    n_vld = m_vld; n_tagv = m_tagv; n_par = m_par; n_tag = m_tag;
    if (bus.flush_s1) n_vld = 0;
    else if (!bus.stall_s1) begin
      n_vld = bus.rd_vld_s0; n_tagv = bus.tagv_s0; n_par = bus.tagpar_s0;
      for (int i = 0; i < 4; i++) n_tag[i] = bus.tags_s0[i*TAG_W +: TAG_W];
    end
    n_cnt = (ev && err && m_cnt < (2**CNT_W) - 1) ? m_cnt + 1 : m_cnt;
    n_rr = 0; n_wait = m_wait; n_rc = m_rc; n_fatal = m_fatal;
    if (m_fatal) begin
    end else if (m_rr) begin
      n_wait = !bus.flush_s1;
      if (bus.flush_s1) n_rc = 0;
    end else if (m_wait) begin
      if (ev && err) begin
        n_wait = 0;
        if (m_rc < MAX_RETRY) begin n_rr = 1; n_rc = m_rc + 1; end
        else n_fatal = 1;
      end else if (ev || bus.flush_s1) begin
        n_wait = 0; n_rc = 0;
      end
    end else if (ev && err) begin
      n_rr = 1; n_rc = 1;
    end
  end

  always @(posedge clk) begin
    if (rst_l) begin
      m_vld = n_vld; m_tag = n_tag; m_tagv = n_tagv; m_par = n_par;
      m_cnt = n_cnt; m_rc = n_rc; m_rr = n_rr; m_wait = n_wait; m_fatal = n_fatal;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_s0(input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                        input logic [TAG_W-1:0] t2, input logic [TAG_W-1:0] t3,
                        input logic [3:0] v, input logic [3:0] flip);
    bus.tags_s0   = {t3, t2, t1, t0};
    bus.tagv_s0   = v;
    bus.tagpar_s0 = {^t3, ^t2, ^t1, ^t0} ^ flip;
    bus.rd_vld_s0 = 1'b1;
  endtask

  // Present one S0 read and move to the middle of its S1 cycle
  task automatic one_shot(input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                          input logic [TAG_W-1:0] t2, input logic [TAG_W-1:0] t3,
                          input logic [3:0] v, input logic [3:0] flip);
    step();
    set_s0(t0, t1, t2, t3, v, flip);
    step();
    bus.rd_vld_s0 = 1'b0;
    mid();
  endtask

  initial begin
    int pulses;
    rst_l = 1'b1;
    bus.rd_vld_s0 = 0; bus.tags_s0 = '0; bus.tagv_s0 = 0; bus.tagpar_s0 = 0;
    bus.stall_s1 = 0; bus.flush_s1 = 0; bus.ptag_s1 = PT;
    bus.cam_vld_s1 = 1; bus.tlb_cam_miss_s1 = 0;
    #1 rst_l = 1'b0;
    repeat (3) step();
    rst_l = 1'b1;
    mid();
    chk("rst_waysel", 32'(bus.waysel_buf_s1), 32'h0);
    chk("rst_hit",    32'(bus.hit_s1), 32'h0);
    chk("rst_fatal",  32'(bus.fatal_err), 32'h0);
    chk("rst_cnt",    32'(bus.tag_err_cnt), 32'h0);

    // single hit in way 2
    one_shot(PT ^ 1, PT ^ 2, PT, PT ^ 3, 4'hF, 4'h0);
    chk("w2_waysel", 32'(bus.waysel_buf_s1), 32'h4);
    chk("w2_hit",    32'(bus.hit_s1), 32'h1);
    chk("w2_multi",  32'(bus.multihit_s1), 32'h0);

    // ways 0 and 3 both match
    one_shot(PT, PT ^ 1, PT ^ 2, PT, 4'hF, 4'h0);
    chk("w03_waysel", 32'(bus.waysel_buf_s1), 32'h9);
    chk("w03_multi",  32'(bus.multihit_s1), 32'h1);
    chk("w03_hit",    32'(bus.hit_s1), 32'h1);

    // clean miss, and a matching but invalid way
    one_shot(PT ^ 1, PT ^ 2, PT ^ 3, PT ^ 4, 4'hF, 4'h0);
    chk("miss_miss", 32'(bus.miss_s1), 32'h1);
    one_shot(PT, PT ^ 1, PT ^ 2, PT ^ 3, 4'b1110, 4'h0);
    chk("inv_waysel", 32'(bus.waysel_buf_s1), 32'h0);
    chk("inv_miss",   32'(bus.miss_s1), 32'h1);

    // ITLB miss suppresses hit/miss but not waysel
    step();
    set_s0(PT ^ 1, PT, PT ^ 2, PT ^ 3, 4'hF, 4'h0);
    step();
    bus.rd_vld_s0 = 0; bus.tlb_cam_miss_s1 = 1;
    mid();
    chk("tlbm_waysel", 32'(bus.waysel_buf_s1), 32'h2);
    chk("tlbm_hit",    32'(bus.hit_s1), 32'h0);
    chk("tlbm_miss",   32'(bus.miss_s1), 32'h0);
    step();
    bus.tlb_cam_miss_s1 = 0;

    // way 1 parity error: one retry pulse, counter to 1
    one_shot(PT ^ 1, PT, PT ^ 2, PT ^ 3, 4'hF, 4'b0010);
    chk("perr_alltag", 32'(bus.alltag_err_s1), PAR_EN ? 32'h2 : 32'h0);
    chk("perr_hit",    32'(bus.hit_s1), PAR_EN ? 32'h0 : 32'h1);
    mid();
    chk("perr_retry1", 32'(bus.retry_req), PAR_EN ? 32'h1 : 32'h0);
    chk("perr_cnt",    32'(bus.tag_err_cnt), PAR_EN ? 32'h1 : 32'h0);
    mid();
    chk("perr_retry0", 32'(bus.retry_req), 32'h0);
    // clean replay returns the sequencer to idle
    one_shot(PT ^ 1, PT, PT ^ 2, PT ^ 3, 4'hF, 4'h0);
    chk("replay_hit", 32'(bus.hit_s1), 32'h1);

    // stall holds S1 and blocks the event; releasing it lets the hit through
    step();
    set_s0(PT ^ 1, PT ^ 2, PT, PT ^ 3, 4'hF, 4'h0);
    step();
    bus.rd_vld_s0 = 0; bus.stall_s1 = 1;
    mid();
    chk("stall_hit", 32'(bus.hit_s1), 32'h0);
    step();
    mid();
    chk("stall_hold", 32'(bus.waysel_buf_s1), 32'h4);
    step();
    bus.stall_s1 = 0;
    mid();
    chk("unstall_hit", 32'(bus.hit_s1), 32'h1);

    // stall + flush together: flush wins, S1 empties
    step();
    set_s0(PT ^ 1, PT ^ 2, PT, PT ^ 3, 4'hF, 4'h0);
    step();
    bus.rd_vld_s0 = 0; bus.stall_s1 = 1; bus.flush_s1 = 1;
    step();
    bus.stall_s1 = 0; bus.flush_s1 = 0;
    mid();
    chk("sf_waysel", 32'(bus.waysel_buf_s1), 32'h0);
    chk("sf_hit",    32'(bus.hit_s1), 32'h0);
    chk("sf_miss",   32'(bus.miss_s1), 32'h0);

    // reset while waiting after a replay request
    one_shot(PT ^ 1, PT, PT ^ 2, PT ^ 3, 4'hF, 4'b0010);
    step();
    step();
    rst_l = 0;
    #1;
    chk("rstw_retry", 32'(bus.retry_req), 32'h0);
    chk("rstw_cnt",   32'(bus.tag_err_cnt), 32'h0);
    step();
    rst_l = 1;

    // persistent error: two replays, then fatal; keep going to saturate the counter
    step();
    set_s0(PT ^ 1, PT, PT ^ 2, PT ^ 3, 4'hF, 4'b0010);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (bus.retry_req === 1'b1) pulses++;
    end
    chk("pers_pulses", 32'(pulses), PAR_EN ? 32'd2 : 32'd0);
    chk("pers_fatal",  32'(bus.fatal_err), PAR_EN ? 32'h1 : 32'h0);
    repeat (260) step();
    mid();
    chk("sat_cnt",   32'(bus.tag_err_cnt), PAR_EN ? 32'd255 : 32'd0);
    chk("sat_fatal", 32'(bus.fatal_err), PAR_EN ? 32'h1 : 32'h0);
    bus.rd_vld_s0 = 0;
    step();
    rst_l = 0;
    step();
    rst_l = 1;
    mid();
    chk("end_fatal", 32'(bus.fatal_err), 32'h0);
    chk("end_cnt",   32'(bus.tag_err_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
